// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: in-order fetch-to-decode instruction FIFO with a valid/ready output,
// a stall that leaves one skid slot for the in-flight fetch, flush, and a sticky overflow flag.
module fetch_decode_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [31:0]             in_pc,
    input  logic [31:0]             in_instr,
    input  logic                    flush,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [31:0]             out_pc,
    output logic [31:0]             out_instr,
    output logic                    stall_out,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          push, pop, full, push_eff;

    // A push into a full queue still lands when the head pops in the same cycle.
    always_comb begin
        full       = count_q == CW'(DEPTH);
        push       = in_valid & ~flush;
        pop        = out_valid & out_ready & ~flush;
        push_eff   = push & (~full | pop);
        head_d     = flush ? '0 : head_q + AW'(pop);
        tail_d     = flush ? '0 : tail_q + AW'(push_eff);
        count_d    = flush ? '0 : count_q + CW'(push_eff) - CW'(pop);
        overflow_d = overflow_q | (push & ~push_eff);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) begin
            pc_mem[tail_q]    <= in_pc;
            instr_mem[tail_q] <= in_instr;
        end
    end

    assign out_valid = count_q != '0;
    assign out_pc    = out_valid ? pc_mem[head_q] : 32'h0;
    assign out_instr = out_valid ? instr_mem[head_q] : NOP_WORD;
    assign stall_out = count_q >= CW'(DEPTH - 1);
    assign count     = count_q;
    assign overflow  = overflow_q;
endmodule
